// File: rtl/prco_mem_arb.sv
// Fetch/data memory arbiter: combinational grants, 1-cycle registered read response tag.
// Latency 0 for grants, 1 for read data; losers must hold requests (nothing is latched).
module prco_mem_arb #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_f_req,
  input  logic [AW-1:0] i_f_addr,
  output logic          q_f_gnt,
  output logic          q_f_rvalid,
  output logic [DW-1:0] q_f_rdata,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          q_d_gnt,
  output logic          q_d_rvalid,
  output logic [DW-1:0] q_d_rdata,
  output logic          q_mem_en,
  output logic          q_mem_we,
  output logic [AW-1:0] q_mem_addr,
  output logic [DW-1:0] q_mem_din,
  input  logic [DW-1:0] i_mem_dout
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DATA  = 2'd2
  } tag_t;

  tag_t          tag_q, tag_d;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          f_ok, d_ok, starved;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tag_q      <= TAG_NONE;
      starve_cnt <= '0;
    end else begin
      tag_q      <= tag_d;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    f_ok       = i_f_req && !i_flush && !i_reset;
    d_ok       = i_d_req && !i_reset;
    starved    = (starve_cnt == SW'(STARVE_MAX));
    // Data wins ties until fetch has waited STARVE_MAX data grants.
    q_f_gnt    = f_ok && (!d_ok || starved);
    q_d_gnt    = d_ok && !q_f_gnt;

    q_mem_en   = 1'b0;
    q_mem_we   = 1'b0;
    q_mem_addr = '0;
    q_mem_din  = '0;
    tag_d      = TAG_NONE;
    if (q_f_gnt) begin
      q_mem_en   = 1'b1;
      q_mem_addr = i_f_addr;
      q_mem_din  = i_d_wdata;
      tag_d      = TAG_FETCH;
    end else if (q_d_gnt) begin
      q_mem_en   = 1'b1;
      q_mem_we   = i_d_we;
      q_mem_addr = i_d_addr;
      q_mem_din  = i_d_wdata;
      tag_d      = i_d_we ? TAG_NONE : TAG_DATA;
    end

    starve_nxt = starve_cnt;
    if (i_flush || !i_f_req || q_f_gnt)
      starve_nxt = '0;
    else if (q_d_gnt && !starved)
      starve_nxt = starve_cnt + SW'(1);
  end

  // A fetch response landing during a flush belongs to the cancelled stream.
  always_comb begin
    q_f_rvalid = (tag_q == TAG_FETCH) && !i_flush;
    q_d_rvalid = (tag_q == TAG_DATA);
    q_f_rdata  = q_f_rvalid ? i_mem_dout : '0;
    q_d_rdata  = q_d_rvalid ? i_mem_dout : '0;
  end

endmodule

// File: tb/tb_prco_mem_arb.sv
// Directed-vector bench for prco_mem_arb; a monitor pops per-cycle expectations at negedge.
module tb_prco_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        f_req = 1'b0;
  logic [15:0] f_addr = '0;
  logic        f_gnt, f_rvalid;
  logic [15:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [15:0] d_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_din;
  logic [15:0] mem_dout = '0;

  prco_mem_arb #(.AW(16), .DW(16), .STARVE_MAX(3)) dut (
    .i_clk(clk), .i_reset(rst), .i_flush(flush),
    .i_f_req(f_req), .i_f_addr(f_addr), .q_f_gnt(f_gnt),
    .q_f_rvalid(f_rvalid), .q_f_rdata(f_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .q_d_gnt(d_gnt), .q_d_rvalid(d_rvalid), .q_d_rdata(d_rdata),
    .q_mem_en(mem_en), .q_mem_we(mem_we), .q_mem_addr(mem_addr),
    .q_mem_din(mem_din), .i_mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        fg, dg, we;
    logic [15:0] addr, din;
    logic        frv;
    logic [15:0] frd;
    logic        drv;
    logic [15:0] drd;
    int          st;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_n = 0;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, want);
    end
  endtask

  // Monitor: one expectation per cycle, compared away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("f_gnt",    e.cyc, {31'd0, f_gnt},    {31'd0, e.fg});
        chk("d_gnt",    e.cyc, {31'd0, d_gnt},    {31'd0, e.dg});
        chk("mem_en",   e.cyc, {31'd0, mem_en},   {31'd0, e.fg | e.dg});
        chk("mem_we",   e.cyc, {31'd0, mem_we},   {31'd0, e.we});
        chk("mem_addr", e.cyc, {16'd0, mem_addr}, {16'd0, e.addr});
        chk("mem_din",  e.cyc, {16'd0, mem_din},  {16'd0, e.din});
        chk("f_rvalid", e.cyc, {31'd0, f_rvalid}, {31'd0, e.frv});
        chk("f_rdata",  e.cyc, {16'd0, f_rdata},  {16'd0, e.frd});
        chk("d_rvalid", e.cyc, {31'd0, d_rvalid}, {31'd0, e.drv});
        chk("d_rdata",  e.cyc, {16'd0, d_rdata},  {16'd0, e.drd});
        if (e.st >= 0)
          chk("starve_cnt", e.cyc, {30'd0, dut.starve_cnt}, e.st);
      end
    end
  end

  // rmode: 0 = reset low, 1 = reset held high this cycle, 2 = reset pulsed mid-cycle.
  task automatic cyc(
    input int rmode, input logic fl,
    input logic fr, input logic [15:0] fa,
    input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] wd,
    input logic [15:0] dout,
    input logic efg, input logic edg, input logic ewe, input logic [15:0] eaddr, input logic [15:0] edin,
    input logic efrv, input logic [15:0] efrd, input logic edrv, input logic [15:0] edrd,
    input int est);
    exp_t e;
    @(posedge clk);
    #1;
    rst = (rmode == 1);
    flush = fl; f_req = fr; f_addr = fa;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
    mem_dout = dout;
    if (rmode == 2) begin
      #1 rst = 1'b1;
      #1 rst = 1'b0;
    end
    e.cyc = cyc_n; e.fg = efg; e.dg = edg; e.we = ewe; e.addr = eaddr; e.din = edin;
    e.frv = efrv; e.frd = efrd; e.drv = edrv; e.drd = edrd; e.st = est;
    exp_q.push_back(e);
    cyc_n++;
  endtask

  initial begin
    //   rm fl fr fa       dr dw da       wd       dout      fg dg we addr     din      frv frd      drv drd      st
    // Reset held: requests present but nothing granted.
    cyc(1, 0, 1, 16'h0010, 1, 0, 16'h0005, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    // Fetch only, response at T+1.
    cyc(0, 0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 0, 16'h0000, 0);
    // Both requesting: D,D,D,F,D,D,D,F.
    cyc(0, 0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'h0000, 0, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    cyc(0, 0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'hD001, 0, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 1, 16'hD001, 1);
    cyc(0, 0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'hD002, 0, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 1, 16'hD002, 2);
    cyc(0, 0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'hD003, 1, 0, 0, 16'h0100, 16'h0000, 0, 16'h0000, 1, 16'hD003, 3);
    cyc(0, 0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'hF004, 0, 1, 0, 16'h0200, 16'h0000, 1, 16'hF004, 0, 16'h0000, 0);
    cyc(0, 0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'hD005, 0, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 1, 16'hD005, 1);
    cyc(0, 0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'hD006, 0, 1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 1, 16'hD006, 2);
    cyc(0, 0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000, 16'hD007, 1, 0, 0, 16'h0100, 16'h0000, 0, 16'h0000, 1, 16'hD007, 3);
    cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hF008, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'hF008, 0, 16'h0000, 0);
    // Data write: completes in grant cycle, no response.
    cyc(0, 0, 0, 16'h0000, 1, 1, 16'h0042, 16'h1234, 16'h0000, 0, 1, 1, 16'h0042, 16'h1234, 0, 16'h0000, 0, 16'h0000, 0);
    cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    // Fetch at T, flush at T+1 drops its response; data read at T+1 returns at T+2.
    cyc(0, 0, 1, 16'h0020, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'h0020, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    cyc(0, 1, 1, 16'h0020, 1, 0, 16'h0030, 16'h0000, 16'h5555, 0, 1, 0, 16'h0030, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h6666, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h6666, 0);
    // Flush with fetch alone: no grant at all.
    cyc(0, 1, 1, 16'h0020, 0, 0, 16'h0000, 16'h0000, 16'h7777, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    // Build starve count, grant a data read, then pulse reset before its response.
    cyc(0, 0, 1, 16'h0050, 1, 0, 16'h0044, 16'h0000, 16'h0000, 0, 1, 0, 16'h0044, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    cyc(0, 0, 1, 16'h0050, 1, 0, 16'h0044, 16'h0000, 16'h1919, 0, 1, 0, 16'h0044, 16'h0000, 0, 16'h0000, 1, 16'h1919, 1);
    cyc(2, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h2020, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    // Alternating fetch/data reads to addresses 1..4.
    cyc(0, 0, 1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'h0001, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    cyc(0, 0, 0, 16'h0000, 1, 0, 16'h0002, 16'h0000, 16'hA001, 0, 1, 0, 16'h0002, 16'h0000, 1, 16'hA001, 0, 16'h0000, 0);
    cyc(0, 0, 1, 16'h0003, 0, 0, 16'h0000, 16'h0000, 16'hA002, 1, 0, 0, 16'h0003, 16'h0000, 0, 16'h0000, 1, 16'hA002, 0);
    cyc(0, 0, 0, 16'h0000, 1, 0, 16'h0004, 16'h0000, 16'hA003, 0, 1, 0, 16'h0004, 16'h0000, 1, 16'hA003, 0, 16'h0000, 0);
    cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hA004, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'hA004, -1);
    cyc(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0BAD, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
